// File: rtl/spi_data_register_if.sv
// Bus between the SPI receiver and its output holding register.
// Handshake: out_valid is a one-cycle strobe with no ready; every strobe marks
// a fresh out/status pair, and the consumer must take it that cycle.
interface spi_data_register_if;
    logic        new_data;
    logic [23:0] in;
    logic [15:0] out;
    logic [7:0]  status;
    logic        out_valid;
    logic        overrun;

    // SPI receiver side: supplies the frame and the frame-complete flag
    modport master (
        output new_data,
        output in,
        input  out,
        input  status,
        input  out_valid,
        input  overrun
    );

    // Holding register side
    modport slave (
        input  new_data,
        input  in,
        output out,
        output status,
        output out_valid,
        output overrun
    );
endinterface

// File: rtl/spi_data_register.sv
// Output holding register for the SPI temperature-sensor receive path.
// The asynchronous new_data flag is synchronized and rising-edge detected;
// each detected edge latches the measurement word and trailer byte from the
// frame and emits a one-cycle out_valid strobe. The frame bus itself is not
// synchronized: the receiver keeps it stable until the capture has happened.
module spi_data_register #(
    parameter int SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst_n,
    spi_data_register_if.slave bus
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   cap;
    logic [15:0]            out_q;
    logic [7:0]             status_q;
    logic                   out_valid_q;
    logic                   overrun_q;

    // Synchronizer chain on new_data plus one history flop for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.new_data};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Rising edge of the synchronized flag; falling edges are ignored
    assign cap = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Capture the frame fields and strobe out_valid for one cycle per edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= 16'h0000;
            status_q    <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= cap;
            if (cap) begin
                out_q    <= bus.in[23:8];
                status_q <= bus.in[7:0];
            end
        end
    end

    // Sticky flag: a new capture landed while the previous strobe was still up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (cap && out_valid_q) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.out       = out_q;
    assign bus.status    = status_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_spi_data_register.sv
// Directed testbench for spi_data_register at the default SYNC_STAGES = 2.
module tb_spi_data_register;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   pulse_cnt;

    spi_data_register_if bus ();

    spi_data_register #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock: 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count out_valid strobes, sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n && bus.out_valid === 1'b1) pulse_cnt++;
    end

    // Advance n clock edges and settle 1 ns past the last one
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Driver: one new_data pulse of hi cycles high, lo cycles low, with frame on in
    task automatic send_frame(input logic [23:0] frame, input int hi, input int lo);
        bus.in = frame;
        bus.new_data = 1'b1;
        tick(hi);
        bus.new_data = 1'b0;
        tick(lo);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in = 24'hFFFFFF;
        bus.new_data = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            bus.new_data = ~bus.new_data;
            tick(1);
            checks++;
            if ({bus.out, bus.status, bus.out_valid, bus.overrun} !== 26'h0) begin
                errors++;
                $display("FAIL reset_values cycle %0d: out=%h status=%h valid=%b overrun=%b, want all zero",
                         i, bus.out, bus.status, bus.out_valid, bus.overrun);
            end
        end
        bus.new_data = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(4);
        checks++;
        if (pulse_cnt !== 0 || bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_release_low: pulses=%0d out=%h, want 0 and 0000", pulse_cnt, bus.out);
        end
    endtask

    task automatic test_basic_capture();
        pulse_cnt = 0;
        bus.in = 24'h006464;
        tick(1);
        bus.new_data = 1'b1;
        tick(1); // edge N: first sample of new_data = 1
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_N: out_valid=%b, want 0", bus.out_valid);
        end
        tick(1); // edge N+1
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL basic_early_N1: out_valid=%b out=%h, want 0 and 0000", bus.out_valid, bus.out);
        end
        tick(1); // edge N+2: capture
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 16'h0064 || bus.status !== 8'h64) begin
            errors++;
            $display("FAIL basic_capture: out_valid=%b out=%h status=%h, want 1 0064 64",
                     bus.out_valid, bus.out, bus.status);
        end
        tick(1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_strobe_width: out_valid=%b, want 0", bus.out_valid);
        end
        bus.new_data = 1'b0;
        tick(4);
        checks++;
        if (pulse_cnt !== 1 || bus.out !== 16'h0064 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: pulses=%0d out=%h overrun=%b, want 1 0064 0",
                     pulse_cnt, bus.out, bus.overrun);
        end
    endtask

    task automatic test_sequence();
        logic [23:0] frames [2];
        frames[0] = 24'h000000;
        frames[1] = 24'h004444;
        for (int i = 0; i < 2; i++) begin
            pulse_cnt = 0;
            send_frame(frames[i], 3, 4);
            checks++;
            if (pulse_cnt !== 1 || bus.out !== frames[i][23:8] || bus.status !== frames[i][7:0]) begin
                errors++;
                $display("FAIL sequence_frame%0d: pulses=%0d out=%h status=%h, want 1 %h %h",
                         i, pulse_cnt, bus.out, bus.status, frames[i][23:8], frames[i][7:0]);
            end
        end
    endtask

    task automatic test_no_edge();
        pulse_cnt = 0;
        bus.in = 24'h00C8A5;
        bus.new_data = 1'b1;
        tick(4);
        bus.in = 24'hABCDEF;
        tick(16);
        checks++;
        if (pulse_cnt !== 1 || bus.out !== 16'h00C8 || bus.status !== 8'hA5) begin
            errors++;
            $display("FAIL held_high: pulses=%0d out=%h status=%h, want 1 00c8 a5",
                     pulse_cnt, bus.out, bus.status);
        end
        bus.new_data = 1'b0;
        tick(5);
        checks++;
        if (pulse_cnt !== 1 || bus.out !== 16'h00C8 || bus.status !== 8'hA5) begin
            errors++;
            $display("FAIL falling_edge: pulses=%0d out=%h status=%h, want 1 00c8 a5",
                     pulse_cnt, bus.out, bus.status);
        end
    endtask

    task automatic test_async_reset_mid();
        pulse_cnt = 0;
        bus.in = 24'h123456;
        bus.new_data = 1'b1;
        tick(1); // edge N samples new_data high
        bus.new_data = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out !== 16'h0000 || bus.status !== 8'h00 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: out=%h status=%h valid=%b, want 0000 00 0",
                     bus.out, bus.status, bus.out_valid);
        end
        tick(1);
        rst_n = 1'b1;
        tick(5);
        checks++;
        if (pulse_cnt !== 0 || bus.out !== 16'h0000 || bus.status !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_pipeline: pulses=%0d out=%h status=%h, want 0 0000 00",
                     pulse_cnt, bus.out, bus.status);
        end
    endtask

    task automatic test_reset_release_high();
        pulse_cnt = 0;
        rst_n = 1'b0;
        bus.in = 24'h0A0B0C;
        bus.new_data = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        checks++;
        if (pulse_cnt !== 1 || bus.out !== 16'h0A0B || bus.status !== 8'h0C) begin
            errors++;
            $display("FAIL release_high: pulses=%0d out=%h status=%h, want 1 0a0b 0c",
                     pulse_cnt, bus.out, bus.status);
        end
        bus.new_data = 1'b0;
        tick(3);
    endtask

    task automatic test_back_to_back();
        bus.in = 24'h111111;
        bus.new_data = 1'b1;
        tick(1);
        bus.new_data = 1'b0;
        tick(1);
        bus.in = 24'h222222;
        bus.new_data = 1'b1;
        tick(1);
        bus.new_data = 1'b0;
        tick(6);
        checks++;
        if ((^bus.out) === 1'bx || (^bus.status) === 1'bx || bus.overrun === 1'bx || bus.out_valid === 1'bx) begin
            errors++;
            $display("FAIL fast_no_x: out=%h status=%h overrun=%b valid=%b, want no X",
                     bus.out, bus.status, bus.overrun, bus.out_valid);
        end
        checks++;
        if (bus.out !== 16'h1111 && bus.out !== 16'h2222) begin
            errors++;
            $display("FAIL fast_frame: out=%h, want 1111 or 2222", bus.out);
        end
    endtask

    task automatic test_legal_spacing();
        logic [23:0] frames [3];
        frames[0] = 24'h0190AA;
        frames[1] = 24'hFF3855;
        frames[2] = 24'h7F0001;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        pulse_cnt = 0;
        for (int i = 0; i < 3; i++) send_frame(frames[i], 2, 2);
        tick(4);
        checks++;
        if (pulse_cnt !== 3 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL legal_spacing: pulses=%0d overrun=%b, want 3 and 0", pulse_cnt, bus.overrun);
        end
        checks++;
        if (bus.out !== 16'h7F00 || bus.status !== 8'h01) begin
            errors++;
            $display("FAIL legal_last_frame: out=%h status=%h, want 7f00 01", bus.out, bus.status);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pulse_cnt = 0;
        rst_n = 1'b0;
        bus.new_data = 1'b0;
        bus.in = 24'h000000;
        test_reset();
        test_basic_capture();
        test_sequence();
        test_no_edge();
        test_async_reset_mid();
        test_reset_release_high();
        test_back_to_back();
        test_legal_spacing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_data_register.md
# spi_data_register

Output holding register for the SPI temperature-sensor receive path. When the SPI receiver signals a completed 24-bit frame on `new_data`, this block latches the 16-bit measurement field `in[23:8]` into `out`. It also latches the 8-bit trailer `in[7:0]` into `status`, and raises a one-cycle `out_valid` strobe for downstream logic. `new_data` is treated as asynchronous to `clk` and is synchronized before use.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `new_data`; legal values are 2 or greater.
- `clk`  input  1: system clock; all state updates on its rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `new_data`  input  1: frame-complete flag from the SPI receiver; asynchronous; a rising edge means `in` holds a complete, stable frame.
- `in`  input  24: received frame. `[23:8]` is the measurement word (MSB first); `[7:0]` is the status/trailer byte.
- `out`  output  16: last captured measurement word, `in[23:8]`.
- `status`  output  8: last captured trailer byte, `in[7:0]`.
- `out_valid`  output  1: single-cycle pulse on every capture.
- `overrun`  output  1: sticky flag; set when a capture occurs while `out_valid` is still high from the previous capture.

## Operation
- `new_data` passes through a `SYNC_STAGES`-deep flop chain, followed by one further history flop.
- A rising-edge detect on that chain gives `cap = sync_last & ~hist`.
- When `cap` is 1, at the next clock edge:
  - `out` ← `in[23:8]`
  - `status` ← `in[7:0]`
  - `out_valid` ← 1
- When `cap` is 0: `out` and `status` hold, and `out_valid` ← 0.
- `in` is sampled directly, with no synchronizer. The SPI receiver guarantees `in` is stable from the `new_data` rising edge until `SYNC_STAGES`+2 `clk` cycles later.
- Changes on `in` while `new_data` is static have no effect on any output.
- `new_data` held high for many cycles produces exactly one capture. A new capture requires `new_data` to go low, then high again.
- Falling edges of `new_data` cause no action.
- `overrun` is set on the edge where `cap` is 1 and `out_valid` is 1. It is cleared only by reset.
- Data is passed through unchanged: no sign extension, scaling or arithmetic.

## Timing
- Reset values while `rst_n` = 0 (taking effect immediately, asynchronously):
  - `out` = 16'h0000
  - `status` = 8'h00
  - `out_valid` = 0
  - `overrun` = 0
  - all synchronizer and history flops = 0
- Latency: let edge N be the first `clk` rising edge that samples `new_data` = 1. `cap` asserts after edge N+`SYNC_STAGES`−1. `out`, `status` and `out_valid` update on edge N+`SYNC_STAGES`, which is edge N+2 at the default.
- `out_valid` is high for exactly one cycle per capture.
- `new_data` pulses must be at least 2 `clk` periods high and at least 2 `clk` periods low to be detected reliably. Minimum capture spacing is therefore 4 cycles.
- A `new_data` rising edge that arrives while `rst_n` = 0 is lost. Because the flops reset to 0, `new_data` still high at reset release counts as a rising edge and produces one capture `SYNC_STAGES` edges after release.
- Reset asserted mid-capture, anywhere in the synchronizer pipeline: the capture is aborted and outputs read the reset values.

## Test plan
- Reset: `rst_n` = 0 with `in` = 24'hFFFFFF and `new_data` toggling → `out` = 0, `status` = 0, `out_valid` = 0 and `overrun` = 0 throughout reset.
- Basic capture: `in` = 24'h006464, then a `new_data` rising edge → `out` = 16'h0064 (100), `status` = 8'h64, with a one-cycle `out_valid` 2 edges after first sampled high.
- Sequence: captures of 24'h000000 then 24'h004444 → `out` = 16'h0000, then 16'h0044 (68) with `status` = 8'h44; exactly one `out_valid` pulse per frame.
- No edge, no update: `new_data` held high for 20 cycles while `in` changes to 24'hABCDEF → single capture only; `out` keeps its first value with no further `out_valid`.
- Async reset mid-pipeline: `rst_n` pulsed low 1 cycle after a `new_data` rising edge, with `new_data` already low again at reset release → no capture; `out` = 0.
- Overrun: with `SYNC_STAGES` = 2, two back-to-back 1-cycle-high/1-cycle-low `new_data` pulses → `overrun` is not required to set, no X propagates, and `out` equals one of the two frames. Legal 4-cycle spacing → `overrun` stays 0.
